// File: rtl/apb_adder_arbiter.sv
// Round-robin APB master that shares one operand/adder slave between NREQ requesters.
// Each granted job runs three APB transfers: write A, write B, then read the sum.
module apb_adder_arbiter #(
    parameter int          NREQ      = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int          TIMEOUT   = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [31:0]          result,
    output logic                 busy,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PRWADDR,
    output logic [31:0]          PRWDATA,
    output logic [1:0]           f,
    input  logic [31:0]          PRDATA1,
    input  logic                 PREADY
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP_A, ACCESS_A, SETUP_B, ACCESS_B, SETUP_C, ACCESS_C, DONE
    } state_t;

    state_t          r_state, w_next;
    logic [IW-1:0]   r_last, r_idx, w_win_idx;
    logic            w_win_vld;
    logic [NREQ-1:0] r_gnt;
    logic [31:0]     r_a, r_b, r_result;
    logic            r_err;
    logic [CW-1:0]   r_wait;
    logic            w_access, w_setup, w_timeout;

    assign w_access  = (r_state == ACCESS_A) || (r_state == ACCESS_B) || (r_state == ACCESS_C);
    assign w_setup   = (r_state == SETUP_A)  || (r_state == SETUP_B)  || (r_state == SETUP_C);
    // r_wait counts prior unready ACCESS cycles, so TIMEOUT-1 here means this is the last one allowed.
    assign w_timeout = w_access && !PREADY && (r_wait == CW'(TIMEOUT - 1));

    // Search starts just after the last-served requester; the nearest requesting index wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(r_last) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                w_win_vld = 1'b1;
                w_win_idx = IW'(idx);
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_win_vld) w_next = SETUP_A;
            SETUP_A:  w_next = ACCESS_A;
            ACCESS_A: if (PREADY) w_next = SETUP_B; else if (w_timeout) w_next = DONE;
            SETUP_B:  w_next = ACCESS_B;
            ACCESS_B: if (PREADY) w_next = SETUP_C; else if (w_timeout) w_next = DONE;
            SETUP_C:  w_next = ACCESS_C;
            ACCESS_C: if (PREADY || w_timeout) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_last   <= IW'(NREQ - 1);
            r_idx    <= '0;
            r_gnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_wait   <= '0;
        end else begin
            if (r_state == IDLE && w_win_vld) begin
                r_idx <= w_win_idx;
                r_gnt <= NREQ'(1) << w_win_idx;
                r_a   <= req_a[32*w_win_idx +: 32];
                r_b   <= req_b[32*w_win_idx +: 32];
            end
            if (w_setup)
                r_wait <= '0;
            else if (w_access && !PREADY)
                r_wait <= r_wait + 1'b1;
            if (r_state == ACCESS_C && PREADY)
                r_result <= PRDATA1;
            if (w_timeout) begin
                r_result <= '0;
                r_err    <= 1'b1;
            end
            if (r_state == DONE) begin
                r_gnt  <= '0;
                r_last <= r_idx;
                r_err  <= 1'b0;
            end
        end
    end

    // APB outputs are pure state decodes over registered operands.
    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PRWADDR = '0;
        PRWDATA = '0;
        f       = 2'b00;
        case (r_state)
            SETUP_A, ACCESS_A: begin
                PSEL = 1'b1; PWRITE = 1'b1; f = 2'b01;
                PRWADDR = ADDR_BASE; PRWDATA = r_a;
            end
            SETUP_B, ACCESS_B: begin
                PSEL = 1'b1; PWRITE = 1'b1; f = 2'b10;
                PRWADDR = ADDR_BASE + 32'd4; PRWDATA = r_b;
            end
            SETUP_C, ACCESS_C: begin
                PSEL = 1'b1; f = 2'b11;
                PRWADDR = ADDR_BASE + 32'd8;
            end
            default: ;
        endcase
        PENABLE = w_access;
    end

    assign gnt    = r_gnt;
    assign done   = (r_state == DONE) ? r_gnt : '0;
    assign err    = (r_state == DONE) && r_err;
    assign result = r_result;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_apb_adder_arbiter.sv
// Directed bench for apb_adder_arbiter with a behavioural operand/adder APB slave.
module tb_apb_adder_arbiter;
    localparam int NREQ = 2;

    logic            PCLK = 1'b0;
    logic            PRESET = 1'b1;
    logic [1:0]      req = '0;
    logic [63:0]     req_a = '0, req_b = '0;
    logic [1:0]      gnt, done;
    logic            err, busy, PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0]     result, PRWADDR, PRWDATA, PRDATA1;
    logic [1:0]      f;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave: PREADY one edge after it sees PENABLE, optional stuck-low in the B phase.
    logic [31:0] s_a, s_b;
    logic        stuck_b = 1'b0;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY <= 1'b0; s_a <= '0; s_b <= '0;
        end else begin
            PREADY <= PSEL && PENABLE && !PREADY && !(stuck_b && f == 2'b10);
            if (PSEL && PENABLE && PREADY && PWRITE) begin
                if (f == 2'b01) s_a <= PRWDATA;
                if (f == 2'b10) s_b <= PRWDATA;
            end
        end
    end
    assign PRDATA1 = s_a + s_b;

    apb_adder_arbiter #(.NREQ(NREQ), .ADDR_BASE(32'h0), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PRWADDR(PRWADDR),
        .PRWDATA(PRWDATA), .f(f), .PRDATA1(PRDATA1), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // {PSEL,PENABLE,f} for cycles 1..10 of a job
    localparam logic [3:0] PH [0:9] = '{4'b1001, 4'b1101, 4'b1101, 4'b1010, 4'b1110,
                                        4'b1110, 4'b1011, 4'b1111, 4'b1111, 4'b0000};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {gnt, done, err, result, busy, PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA, f};
    endfunction

    // Called at the negedge of cycle 0; waits for done and checks when and what it delivered.
    task automatic run_job(input string tag, input int idx, input logic [31:0] res,
                           input logic e, input int cyc);
        int c;
        c = 0;
        do begin
            @(negedge PCLK);
            c++;
        end while (done == '0 && c < 200);
        check({tag, "_cyc"}, c, cyc);
        check({tag, "_done"}, done, 2'(1) << idx);
        check({tag, "_gnt"}, gnt, 2'(1) << idx);
        check({tag, "_res"}, result, res);
        check({tag, "_err"}, err, e);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    initial begin
        // reset state
        #1 check("rst_outs", all_outs(), '0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;

        // single job with phase-by-phase protocol check; req and operands change after grant
        req_a[31:0] = 32'd5; req_b[31:0] = 32'd7; req = 2'b01;
        for (int c = 1; c <= 10; c++) begin
            @(negedge PCLK);
            check($sformatf("ph%0d", c), {PSEL, PENABLE, f}, PH[c-1]);
            if (c == 1 || c == 4 || c == 7) check($sformatf("addr%0d", c), PRWADDR, ((c - 1) / 3) * 4);
            if (c == 1) begin
                check("wdata_a", PRWDATA, 32'd5);
                req = 2'b00;
            end
            if (c == 2) begin
                req_a[31:0] = 32'hDEAD; req_b[31:0] = 32'hBEEF;
            end
            if (c == 4) check("wdata_b", PRWDATA, 32'd7);
            if (c == 5) check("busy_mid", busy, 1'b1);
        end
        check("j1_done", done, 2'b01);
        check("j1_res", result, 32'd12);
        check("j1_err", err, 1'b0);
        @(negedge PCLK);
        check("j1_idle", {gnt, busy, done}, '0);
        check("j1_hold", result, 32'd12);

        // simultaneous requests after reset: 0 first, then 1 back-to-back
        do_reset();
        req_a = {32'd10, 32'd1}; req_b = {32'd20, 32'd2}; req = 2'b11;
        run_job("rr0", 0, 32'd3, 1'b0, 10);
        req = 2'b10;
        run_job("rr1", 1, 32'd30, 1'b0, 11);
        req = 2'b00;
        @(negedge PCLK);

        // continuous requests alternate
        req = 2'b11;
        run_job("alt0", 0, 32'd3, 1'b0, 10);
        run_job("alt1", 1, 32'd30, 1'b0, 11);
        run_job("alt2", 0, 32'd3, 1'b0, 11);
        run_job("alt3", 1, 32'd30, 1'b0, 11);
        req = 2'b00;
        @(negedge PCLK);

        // 32-bit wraparound
        req_a[31:0] = 32'hFFFFFFFF; req_b[31:0] = 32'd1; req = 2'b01;
        run_job("wrap1", 0, 32'd0, 1'b0, 10);
        req = 2'b00;
        @(negedge PCLK);
        req_a[63:32] = 32'h12345678; req_b[63:32] = 32'h11111111; req = 2'b10;
        run_job("plain", 1, 32'h23456789, 1'b0, 10);
        req = 2'b00;
        @(negedge PCLK);
        req_a[31:0] = 32'h80000000; req_b[31:0] = 32'h80000000; req = 2'b01;
        run_job("wrap2", 0, 32'd0, 1'b0, 10);
        req = 2'b00;
        @(negedge PCLK);

        // slave stuck in B phase: abort 16 cycles after ACCESS_B entry (cycle 5)
        stuck_b = 1'b1;
        req_a[63:32] = 32'd3; req_b[63:32] = 32'd4; req = 2'b10;
        run_job("tmo", 1, 32'd0, 1'b0 | 1'b1, 21);
        req = 2'b00; stuck_b = 1'b0;
        @(negedge PCLK);
        check("tmo_idle", {busy, err}, '0);
        req = 2'b10;
        run_job("post_tmo", 1, 32'd7, 1'b0, 10);
        req = 2'b00;
        @(negedge PCLK);

        // reset in the middle of ACCESS_A
        req_a[31:0] = 32'd9; req_b[31:0] = 32'd9; req = 2'b01;
        @(negedge PCLK);
        @(negedge PCLK);
        check("pre_rst_acc", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        #1 check("mid_rst_outs", all_outs(), '0);
        req = 2'b10; req_a[63:32] = 32'd100; req_b[63:32] = 32'd23;
        @(negedge PCLK);
        PRESET = 1'b0;
        run_job("post_rst", 1, 32'd123, 1'b0, 10);
        req = 2'b00;
        @(negedge PCLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
